// File: rtl/axil_regbank.sv
// AXI4-Lite slave register bank: register 0 is a read-only ID, the rest are
// byte-writable 32-bit registers. Independent single-outstanding read and write paths.
module axil_regbank #(
    parameter int          NUM_REGS = 16,
    parameter logic [31:0] ID_VALUE = 32'h5953_5958
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp
);

    localparam int         IDX_W     = $clog2(NUM_REGS);
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLV  = 2'b10;

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

    function automatic logic addr_in_range(input logic [31:0] addr);
        return (addr >> (IDX_W + 2)) == 32'd0;
    endfunction

    function automatic logic [IDX_W-1:0] addr_index(input logic [31:0] addr);
        return IDX_W'(addr >> 2);
    endfunction

    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) res[8*k +: 8] = new_v[8*k +: 8];
            else         res[8*k +: 8] = old_v[8*k +: 8];
        end
        return res;
    endfunction

    wstate_t            wstate_r;
    rstate_t            rstate_r;
    logic [31:0]        regs_r [NUM_REGS];
    logic               awready_r, wready_r, aw_held_r, w_held_r;
    logic [31:0]        awaddr_r, wdata_r;
    logic [3:0]         wstrb_r;
    logic               bvalid_r, arready_r, rvalid_r;
    logic [1:0]         bresp_r, rresp_r;
    logic [31:0]        rdata_r;

    logic [31:0]        wr_addr_s, wr_data_s;
    logic [3:0]         wr_strb_s;
    logic               aw_got_s, w_got_s, commit_s, wr_ok_s;
    logic [IDX_W-1:0]   wr_idx_s, rd_idx_s;
    logic               rd_ok_s;
    logic [31:0]        rd_value_s;

    // Write-side decode: a beat captured earlier takes precedence over the live bus.
    always_comb begin
        wr_addr_s = aw_held_r ? awaddr_r : awaddr;
        wr_data_s = w_held_r  ? wdata_r  : wdata;
        wr_strb_s = w_held_r  ? wstrb_r  : wstrb;
        aw_got_s  = aw_held_r | (awvalid & awready_r);
        w_got_s   = w_held_r  | (wvalid  & wready_r);
        commit_s  = (wstate_r == W_IDLE) & aw_got_s & w_got_s;
        wr_ok_s   = addr_in_range(wr_addr_s);
        wr_idx_s  = addr_index(wr_addr_s);
    end

    // Read-side decode; sees register contents before any same-edge write.
    always_comb begin
        rd_ok_s    = addr_in_range(araddr);
        rd_idx_s   = addr_index(araddr);
        rd_value_s = 32'h0;
        if (!rd_ok_s)                      rd_value_s = 32'h0;
        else if (rd_idx_s == {IDX_W{1'b0}}) rd_value_s = ID_VALUE;
        else                                rd_value_s = regs_r[rd_idx_s];
    end

    // Write FSM and register storage; commits on the edge completing AW and W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wstate_r  <= W_IDLE;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            awaddr_r  <= 32'h0;
            wdata_r   <= 32'h0;
            wstrb_r   <= 4'h0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
            for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= 32'h0;
        end else begin
            case (wstate_r)
                W_IDLE: begin
                    if (commit_s) begin
                        if (wr_ok_s && (wr_idx_s != {IDX_W{1'b0}}))
                            regs_r[wr_idx_s] <= strb_merge(regs_r[wr_idx_s], wr_data_s, wr_strb_s);
                        bresp_r   <= wr_ok_s ? RESP_OKAY : RESP_SLV;
                        bvalid_r  <= 1'b1;
                        wstate_r  <= W_RESP;
                        awready_r <= 1'b0;
                        wready_r  <= 1'b0;
                        aw_held_r <= 1'b0;
                        w_held_r  <= 1'b0;
                    end else begin
                        if (awvalid && awready_r) begin
                            aw_held_r <= 1'b1;
                            awaddr_r  <= awaddr;
                            awready_r <= 1'b0;
                        end else begin
                            awready_r <= ~aw_held_r;
                        end
                        if (wvalid && wready_r) begin
                            w_held_r <= 1'b1;
                            wdata_r  <= wdata;
                            wstrb_r  <= wstrb;
                            wready_r <= 1'b0;
                        end else begin
                            wready_r <= ~w_held_r;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid_r && bready) begin
                        bvalid_r  <= 1'b0;
                        wstate_r  <= W_IDLE;
                        awready_r <= 1'b1;
                        wready_r  <= 1'b1;
                    end
                end
                default: begin
                    wstate_r  <= W_IDLE;
                    bvalid_r  <= 1'b0;
                    awready_r <= 1'b0;
                    wready_r  <= 1'b0;
                end
            endcase
        end
    end

    // Read FSM; data is registered at the AR handshake and held until accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rstate_r  <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'h0;
            rresp_r   <= RESP_OKAY;
        end else begin
            case (rstate_r)
                R_IDLE: begin
                    if (arvalid && arready_r) begin
                        rdata_r   <= rd_value_s;
                        rresp_r   <= rd_ok_s ? RESP_OKAY : RESP_SLV;
                        rvalid_r  <= 1'b1;
                        arready_r <= 1'b0;
                        rstate_r  <= R_DATA;
                    end else begin
                        arready_r <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rvalid_r && rready) begin
                        rvalid_r  <= 1'b0;
                        arready_r <= 1'b1;
                        rstate_r  <= R_IDLE;
                    end
                end
                default: begin
                    rstate_r  <= R_IDLE;
                    rvalid_r  <= 1'b0;
                    arready_r <= 1'b0;
                end
            endcase
        end
    end

    assign awready = awready_r;
    assign wready  = wready_r;
    assign bvalid  = bvalid_r;
    assign bresp   = bresp_r;
    assign arready = arready_r;
    assign rvalid  = rvalid_r;
    assign rdata   = rdata_r;
    assign rresp   = rresp_r;

endmodule

// File: tb/tb_axil_regbank.sv
// Randomized bench for axil_regbank against an array-based register model,
// plus directed handshake, boundary and reset scenarios.
module tb_axil_regbank;
    localparam int          NUM_REGS = 16;
    localparam logic [31:0] ID_VALUE = 32'h5953_5958;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int vec_count = 0;
    int err_count = 0;
    logic [31:0] model_regs [NUM_REGS];

    axil_regbank #(.NUM_REGS(NUM_REGS), .ID_VALUE(ID_VALUE)) dut (
        .clk(clk), .rst_n(rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_range_m(input logic [31:0] a);
        return a < 32'(NUM_REGS * 4);
    endfunction

    function automatic logic [33:0] model_read(input logic [31:0] a);
        int idx;
        if (!in_range_m(a)) return {2'b10, 32'h0};
        idx = int'(a / 4);
        if (idx == 0) return {2'b00, ID_VALUE};
        return {2'b00, model_regs[idx]};
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d,
                                               input logic [3:0] s);
        int idx;
        if (!in_range_m(a)) return 2'b10;
        idx = int'(a / 4);
        if (idx != 0)
            for (int k = 0; k < 4; k++)
                if (s[k]) model_regs[idx][8*k +: 8] = d[8*k +: 8];
        return 2'b00;
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int hold);
        logic [1:0] eresp;
        bit aw_done, w_done, aw_fire, w_fire;
        int n;
        eresp = model_write(addr, data, strb);
        aw_done = 0; w_done = 0; n = 0;
        bready = (hold == 0);
        while (!(aw_done && w_done) && n < 20) begin
            if (!aw_done && n >= aw_dly) begin awvalid = 1'b1; awaddr = addr; end
            if (!w_done && n >= w_dly) begin wvalid = 1'b1; wdata = data; wstrb = strb; end
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            check("bvalid_before_commit", bvalid, 0);
            tick();
            if (aw_fire) begin aw_done = 1; awvalid = 1'b0; end
            if (w_fire)  begin w_done = 1;  wvalid = 1'b0; end
            n++;
        end
        if (!(aw_done && w_done)) begin
            check("aw_w_capture_timeout", 0, 1);
            awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
            return;
        end
        check("bvalid_after_commit", bvalid, 1);
        check("bresp", bresp, eresp);
        for (int h = 0; h < hold; h++) begin
            check("awready_in_resp", awready, 0);
            check("wready_in_resp", wready, 0);
            tick();
            check("bvalid_held", bvalid, 1);
            check("bresp_held", bresp, eresp);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("bvalid_cleared", bvalid, 0);
        check("awready_back", awready, 1);
        check("wready_back", wready, 1);
    endtask

    task automatic do_read(input logic [31:0] addr, input int hold);
        logic [33:0] exp;
        int n;
        exp = model_read(addr);
        rready = (hold == 0);
        arvalid = 1'b1; araddr = addr;
        n = 0;
        while (!arready && n < 20) begin tick(); n++; end
        if (!arready) begin
            check("arready_timeout", 0, 1);
            arvalid = 1'b0; rready = 1'b0;
            return;
        end
        tick();
        arvalid = 1'b0;
        check("rvalid_after_ar", rvalid, 1);
        check("rdata", rdata, exp[31:0]);
        check("rresp", rresp, exp[33:32]);
        for (int h = 0; h < hold; h++) begin
            check("arready_in_data", arready, 0);
            tick();
            check("rvalid_held", rvalid, 1);
            check("rdata_held", rdata, exp[31:0]);
            check("rresp_held", rresp, exp[33:32]);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("rvalid_cleared", rvalid, 0);
        check("arready_back", arready, 1);
    endtask

    task automatic read_all();
        for (int i = 0; i < NUM_REGS; i++) do_read(32'(i * 4), 0);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0]  s;
        rst_n = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        awaddr = 32'h0; wdata = 32'h0; wstrb = 4'h0; araddr = 32'h0;
        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 32'h0;

        tick(); tick();
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_arready", arready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_bresp", bresp, 0);
        check("rst_rresp", rresp, 0);
        check("rst_rdata", rdata, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_awready", awready, 1);
        check("post_rst_wready", wready, 1);
        check("post_rst_arready", arready, 1);

        // Same-cycle AW+W, then W leading AW by two cycles with sparse strobes.
        do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        do_read(32'h04, 0);
        do_write(32'h08, 32'h11223344, 4'h5, 2, 0, 0);
        do_read(32'h08, 0);
        check("sparse_strobe_value", model_regs[2], 32'h00220044);

        // ID register, out-of-range access, wstrb=0.
        do_write(32'h00, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        do_read(32'h00, 0);
        do_write(32'h40, 32'hCAFEF00D, 4'hF, 0, 1, 0);
        do_read(32'h40, 0);
        do_write(32'h04, 32'h12345678, 4'h0, 1, 0, 0);
        read_all();

        // Back-pressure on B and R.
        do_write(32'h14, 32'h0BADF00D, 4'hF, 0, 0, 5);
        do_read(32'h14, 5);

        // AR handshake on the same edge as a write commit to the same register.
        do_write(32'h0C, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
        awvalid = 1'b1; awaddr = 32'h0C; wvalid = 1'b1; wdata = 32'h5A5A5A5A; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 32'h0C; bready = 1'b1; rready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("race_rvalid", rvalid, 1);
        check("race_rdata_prewrite", rdata, 32'hA5A5A5A5);
        check("race_bvalid", bvalid, 1);
        void'(model_write(32'h0C, 32'h5A5A5A5A, 4'hF));
        tick();
        bready = 1'b0; rready = 1'b0;
        check("race_bvalid_clear", bvalid, 0);
        check("race_rvalid_clear", rvalid, 0);
        do_read(32'h0C, 0);

        // Randomized mixed traffic.
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 1) == 0) a = 32'(NUM_REGS * 4) + 32'($urandom_range(0, 255));
                else                           a = $urandom | 32'h8000_0000;
            end else begin
                a = 32'($urandom_range(0, NUM_REGS - 1) * 4) + 32'($urandom_range(0, 3));
            end
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0)
                do_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
            else
                do_read(a, $urandom_range(0, 2));
        end
        read_all();

        // Reset after AW captured but before W arrives.
        awvalid = 1'b1; awaddr = 32'h10;
        tick();
        awvalid = 1'b0;
        rst_n = 1'b0;
        tick();
        check("midrst_awready", awready, 0);
        check("midrst_wready", wready, 0);
        check("midrst_arready", arready, 0);
        check("midrst_bvalid", bvalid, 0);
        rst_n = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 32'h0;
        tick();
        check("midrst_bvalid_after", bvalid, 0);
        read_all();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end
endmodule

// File: doc/axil_regbank.md
AXIL_REGBANK -- requirements
Module: axil_regbank

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of 32-bit registers (power of two, 2..64).
REQ-002 SHALL have parameter ID_VALUE, default 32'h5953_5958, read-only constant returned by register 0.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have AW channel ports: awvalid in 1; awready out 1; awaddr in 32 (byte address).
REQ-006 SHALL have W channel ports: wvalid in 1; wready out 1; wdata in 32; wstrb in 4 (byte enables).
REQ-007 SHALL have B channel ports: bvalid out 1; bready in 1; bresp out 2 (00 OKAY, 10 SLVERR).
REQ-008 SHALL have AR channel ports: arvalid in 1; arready out 1; araddr in 32.
REQ-009 SHALL have R channel ports: rvalid out 1; rready in 1; rdata out 32; rresp out 2.

Function
REQ-010 SHALL decode register index as addr[log2(NUM_REGS)+1:2]; addr[1:0] ignored; in range iff all bits above the index field are zero.
REQ-011 SHALL implement the write path as FSM W_IDLE -> W_RESP -> W_IDLE.
REQ-012 In W_IDLE: awready=1 until an AW beat is captured; wready=1 until a W beat is captured; the two are captured independently, in either order or in the same cycle.
REQ-013 On the edge where both AW and W are held, SHALL perform the write, load bresp, and enter W_RESP with bvalid=1.
REQ-014 In W_RESP: awready=wready=0; hold bvalid and bresp stable until bvalid&&bready, then clear bvalid and return to W_IDLE on that edge.
REQ-015 Write SHALL update byte lane k of the target register only when wstrb[k]=1; wstrb=0 updates nothing and responds OKAY.
REQ-016 Writes to register 0 SHALL be discarded and respond OKAY; register 0 always reads ID_VALUE.
REQ-017 Out-of-range write SHALL modify no register and respond bresp=SLVERR.
REQ-018 SHALL implement the read path as FSM R_IDLE -> R_DATA -> R_IDLE, independent of the write FSM.
REQ-019 In R_IDLE: arready=1; on arvalid&&arready, SHALL register rdata/rresp and enter R_DATA with rvalid=1 on the next cycle.
REQ-020 In R_DATA: arready=0; hold rvalid, rdata, rresp stable until rvalid&&rready, then clear rvalid and return to R_IDLE.
REQ-021 Out-of-range read SHALL return rdata=0, rresp=SLVERR.
REQ-022 When the AR handshake and a write commit (REQ-013) occur on the same edge to the same register, rdata SHALL be the pre-write value.
REQ-023 Read latency: rvalid SHALL assert exactly one cycle after the AR handshake; bvalid exactly one cycle after the later of the AW/W captures.
REQ-024 Neither FSM SHALL accept a new address while its response is pending; at most one outstanding transaction per direction.

Reset
REQ-025 While rst_n=0 at a rising edge: both FSMs SHALL go idle, clearing the AW/W capture flags and discarding any pending response.
REQ-026 The same reset edge SHALL set bvalid=0, rvalid=0, bresp=00, rresp=00, rdata=0.
REQ-027 The same reset edge SHALL clear registers 1..NUM_REGS-1 to 0.
REQ-028 awready, wready, arready SHALL be 0 while rst_n=0 and 1 from the first cycle after rst_n returns high.
REQ-029 Reset mid-transaction SHALL abort it with no register update if the write had not committed; a committed write is overwritten by the reset clear.

Verification
REQ-030 AW+W same cycle, addr 0x04, wdata 0xDEADBEEF, wstrb 0xF, bready=1 -> bvalid next cycle with OKAY; read 0x04 -> rdata 0xDEADBEEF, OKAY.
REQ-031 W two cycles before AW, addr 0x08, wdata 0x11223344, wstrb 0x5, reg previously 0 -> bvalid one cycle after AW; read -> 0x00220044.
REQ-032 Write 0x00 with 0xFFFFFFFF -> bresp OKAY; read 0x00 -> ID_VALUE 0x59535958. Write and read 0x40 (NUM_REGS=16) -> SLVERR on both; read data 0; all registers unchanged.
REQ-033 bready held low 5 cycles -> bvalid/bresp stable; awready=wready=0 throughout. Same check for rready low, with rdata stable.
REQ-034 Reg 0x0C=0xA5A5A5A5, then write 0x0C with 0x5A5A5A5A committing on the same edge as an AR handshake to 0x0C -> rdata 0xA5A5A5A5; a subsequent read returns 0x5A5A5A5A.
REQ-035 rst_n low for one cycle after AW captured but before W -> no update, bvalid=0, readys 0 during reset; all registers read 0 after release.
